// File: rtl/sample_limiter.sv
// Two-stage elastic offset-and-clamp pipeline with optional clip statistics.
// Define LIMITER_STATS_EN to build the clip counters and sticky flag; otherwise they read as zero.
module sample_limiter #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 8
) (
    input  logic                    m_clock,
    input  logic                    mreset,
    input  logic signed [W_IN-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_IN-1:0]  offset,
    input  logic                    mode,
    input  logic        [W_OUT-1:0] lo,
    input  logic        [W_OUT-1:0] hi,
    output logic        [W_OUT-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [15:0]      clip_lo_cnt,
    output logic        [15:0]      clip_hi_cnt,
    input  logic                    stats_clr,
    output logic                    clip_flag
);

    logic                   s1_valid;
    logic signed [W_IN:0]   s1_sum;
    logic                   s1_mode;
    logic       [W_OUT-1:0] s1_lo;
    logic       [W_OUT-1:0] s1_hi;

    logic                   s2_load;
    logic                   s1_adv;
    logic                   in_xfer;
    logic signed [W_IN:0]   sum_next;
    logic signed [W_IN:0]   lo_ext;
    logic signed [W_IN:0]   hi_ext;
    logic       [W_OUT-1:0] limited;
    logic                   low_clip;
    logic                   high_clip;

    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign in_ready = !s1_valid || s1_adv;
    assign in_xfer  = in_valid && in_ready;

    // One guard bit makes the sum exact for any pair of W_IN-bit operands.
    assign sum_next = {in_data[W_IN-1], in_data} + {offset[W_IN-1], offset};
    assign lo_ext   = {{(W_IN+1-W_OUT){1'b0}}, s1_lo};
    assign hi_ext   = {{(W_IN+1-W_OUT){1'b0}}, s1_hi};

    always_comb begin
        limited   = s1_sum[W_OUT-1:0];
        low_clip  = 1'b0;
        high_clip = 1'b0;
        if (!s1_mode) begin
            // An inverted window collapses onto the lower bound.
            if (s1_lo > s1_hi) begin
                limited  = s1_lo;
                low_clip = 1'b1;
            end else if (s1_sum < lo_ext) begin
                limited  = s1_lo;
                low_clip = 1'b1;
            end else if (s1_sum > hi_ext) begin
                limited   = s1_hi;
                high_clip = 1'b1;
            end
        end
    end

    always_ff @(posedge m_clock) begin
        if (mreset) begin
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Bounds and mode travel with the sample so later changes cannot touch it.
    always_ff @(posedge m_clock) begin
        if (in_xfer) begin
            s1_sum  <= sum_next;
            s1_mode <= mode;
            s1_lo   <= lo;
            s1_hi   <= hi;
        end
    end

    always_ff @(posedge m_clock) begin
        if (mreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= limited;
            end
        end
    end

`ifdef LIMITER_STATS_EN
    // A clip coinciding with a clear wins, so the counter restarts at one.
    always_ff @(posedge m_clock) begin
        if (mreset) begin
            clip_lo_cnt <= '0;
            clip_hi_cnt <= '0;
            clip_flag   <= 1'b0;
        end else begin
            if (s1_adv && low_clip) begin
                if (stats_clr) begin
                    clip_lo_cnt <= 16'd1;
                end else if (clip_lo_cnt != 16'hFFFF) begin
                    clip_lo_cnt <= clip_lo_cnt + 16'd1;
                end
            end else if (stats_clr) begin
                clip_lo_cnt <= '0;
            end

            if (s1_adv && high_clip) begin
                if (stats_clr) begin
                    clip_hi_cnt <= 16'd1;
                end else if (clip_hi_cnt != 16'hFFFF) begin
                    clip_hi_cnt <= clip_hi_cnt + 16'd1;
                end
            end else if (stats_clr) begin
                clip_hi_cnt <= '0;
            end

            if (s1_adv && (low_clip || high_clip)) begin
                clip_flag <= 1'b1;
            end else if (stats_clr) begin
                clip_flag <= 1'b0;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = stats_clr ^ low_clip ^ high_clip;
    assign clip_lo_cnt  = '0;
    assign clip_hi_cnt  = '0;
    assign clip_flag    = 1'b0;
`endif

endmodule

// File: tb/tb_sample_limiter.sv
// Directed bench for sample_limiter (W_IN=W_OUT=8); counter expectations follow LIMITER_STATS_EN.
module tb_sample_limiter;

`ifdef LIMITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        m_clock = 1'b0;
    logic        mreset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  offset;
    logic        mode;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] clip_lo_cnt;
    logic [15:0] clip_hi_cnt;
    logic        stats_clr;
    logic        clip_flag;

    int vectors = 0;
    int miscompares = 0;

    sample_limiter #(.W_IN(8), .W_OUT(8)) dut (
        .m_clock(m_clock),
        .mreset(mreset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .offset(offset),
        .mode(mode),
        .lo(lo),
        .hi(hi),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .clip_lo_cnt(clip_lo_cnt),
        .clip_hi_cnt(clip_hi_cnt),
        .stats_clr(stats_clr),
        .clip_flag(clip_flag)
    );

    always #5 m_clock = ~m_clock;

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] refLimit(input logic [7:0] din, input logic [7:0] off,
                                            input logic md, input logic [7:0] l, input logic [7:0] h);
        int s;
        s = int'($signed(din)) + int'($signed(off));
        if (md) return s[7:0];
        if (l > h) return l;
        if (s < int'(l)) return l;
        if (s > int'(h)) return h;
        return s[7:0];
    endfunction

    // Single sample with out_ready high: checks the two-cycle latency and the result.
    task automatic applyStimulus(input logic [7:0] din, input logic [7:0] exp_out, input string tag,
                                 input logic [7:0] post_lo, input logic [7:0] post_hi);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = din;
        #1;
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lo = post_lo;
        hi = post_hi;
        checkOutput({tag, "_lat1"}, out_valid, 0);
        tick();
        checkOutput({tag, "_lat2"}, out_valid, 1);
        checkOutput({tag, "_data"}, out_data, exp_out);
        tick();
        checkOutput({tag, "_drain"}, out_valid, 0);
    endtask

    task automatic streamRun(input int n, input int first, input int stall_from, input int stall_len,
                             input int exp_fill, input string tag);
        logic [7:0] exp_q[$];
        logic [7:0] held;
        logic [7:0] want;
        int sent = 0;
        int recv = 0;
        int c = 0;
        int acc_stall = 0;
        bit acc;
        bit hs;
        bit stalled;
        held = '0;
        while (recv < n && c < 2000) begin
            stalled   = (c >= stall_from) && (c < stall_from + stall_len);
            out_ready = !stalled;
            in_valid  = (sent < n);
            in_data   = 8'(first + sent);
            #1;
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (stalled && acc) acc_stall++;
            if (stalled && c >= stall_from + 2) begin
                checkOutput({tag, "_rdy_low"}, in_ready, 0);
                if (c == stall_from + 2) begin
                    held = out_data;
                end else begin
                    checkOutput({tag, "_hold_data"}, out_data, held);
                    checkOutput({tag, "_hold_valid"}, out_valid, 1);
                end
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checkOutput({tag, "_extra"}, exp_q.size(), 1);
                end else begin
                    want = exp_q.pop_front();
                    checkOutput({tag, "_data"}, out_data, want);
                end
                recv++;
            end
            if (acc) begin
                exp_q.push_back(refLimit(in_data, offset, mode, lo, hi));
                sent++;
            end
            @(posedge m_clock);
            #1;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput({tag, "_count"}, recv, n);
        checkOutput({tag, "_fill"}, acc_stall, exp_fill);
    endtask

    initial begin
        mreset    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        offset    = '0;
        mode      = 1'b0;
        lo        = 8'd16;
        hi        = 8'd235;
        out_ready = 1'b1;
        stats_clr = 1'b0;
        tick();
        tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_lo_cnt", clip_lo_cnt, 0);
        checkOutput("rst_flag", clip_flag, 0);
        mreset = 1'b0;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // High clip, then the same sum wrapped in bypass mode.
        offset = 8'h7F;
        applyStimulus(8'h70, 8'd235, "hi_clip", 8'd16, 8'd235);
        checkOutput("hi_clip_cnt", clip_hi_cnt, STATS ? 1 : 0);
        checkOutput("hi_clip_flag", clip_flag, STATS);
        mode = 1'b1;
        applyStimulus(8'h70, 8'hEF, "bypass", 8'd16, 8'd235);
        checkOutput("bypass_cnt", clip_hi_cnt, STATS ? 1 : 0);
        mode   = 1'b0;
        offset = 8'h00;

        // Inverted window; bounds change after acceptance must not matter.
        lo = 8'd200;
        hi = 8'd100;
        applyStimulus(8'd150, 8'd200, "inverted", 8'd16, 8'd235);

        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checkOutput("clr_lo_cnt", clip_lo_cnt, 0);
        checkOutput("clr_hi_cnt", clip_hi_cnt, 0);
        checkOutput("clr_flag", clip_flag, 0);

        streamRun(256, 0, 0, 0, 0, "ramp");
        checkOutput("ramp_lo_cnt", clip_lo_cnt, STATS ? 144 : 0);
        checkOutput("ramp_hi_cnt", clip_hi_cnt, 0);
        checkOutput("ramp_flag", clip_flag, STATS);

        // Clear in the same cycle as a low clip: the clip survives.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_valid  = 1'b0;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checkOutput("clrclip_lo_cnt", clip_lo_cnt, STATS ? 1 : 0);
        checkOutput("clrclip_hi_cnt", clip_hi_cnt, 0);
        checkOutput("clrclip_flag", clip_flag, STATS);
        checkOutput("clrclip_data", out_data, 8'd16);
        tick();

        // Fill both stages, then reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd50;
        tick();
        in_data = 8'd51;
        tick();
        in_valid = 1'b0;
        checkOutput("full_out_valid", out_valid, 1);
        checkOutput("full_in_ready", in_ready, 0);
        mreset = 1'b1;
        tick();
        mreset = 1'b0;
        checkOutput("rstfull_out_valid", out_valid, 0);
        checkOutput("rstfull_out_data", out_data, 0);
        checkOutput("rstfull_lo_cnt", clip_lo_cnt, 0);
        checkOutput("rstfull_flag", clip_flag, 0);
        checkOutput("rstfull_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rstfull_no_output", out_valid, 0);
        end

        streamRun(12, 20, 0, 5, 2, "stall_start");
        streamRun(12, 40, 4, 5, 0, "stall_mid");

        in_valid = 1'b1;
        in_data  = 8'h80;
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        checkOutput("sat_lo_cnt", clip_lo_cnt, STATS ? 16'hFFFF : 0);
        checkOutput("sat_flag", clip_flag, STATS);
        checkOutput("sat_data", out_data, 8'd16);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checkOutput("satclr_lo_cnt", clip_lo_cnt, 0);
        checkOutput("satclr_flag", clip_flag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
